dmem_mmio_ctrl: RTL

Parametrised successor to the single-cycle CPU's combinational data memory. Sits on the processor data port behind a request/ready handshake. Adds configurable data width, memory depth and wait states, plus a small memory-mapped I/O region: a GPIO output register, a free-running cycle counter, and a sticky address-error flag. It enables the multicycle/stalling CPU generation and board-level output.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/ram_sp.sv | 25 ++
 rtl/dmem_mmio_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory controller with its MMIO window.
// Imported by the controller top; the RAM sub-module is type-agnostic.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RAM  = 2'd0,
        MMIO = 2'd1,
        ERR  = 2'd2
    } region_e;

    // Register slots inside the MMIO window, counted in data words
    localparam logic [2:0] MMIO_GPIO   = 3'd0;
    localparam logic [2:0] MMIO_CYCLE  = 3'd1;
    localparam logic [2:0] MMIO_STATUS = 3'd2;
    localparam logic [2:0] MMIO_RSVD   = 3'd3;

    localparam int unsigned MMIO_WINDOW_BYTES = 32'd8;

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM: synchronous write, synchronous read (read-before-write).
// Contents are deliberately not reset.
module ram_sp #(
    parameter int unsigned DATA_W = 32'd16,
    parameter int unsigned DEPTH  = 32'd64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage array write and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
        rdata <= mem_r[idx];
    end

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// Data-memory controller: req/ready handshake with wait states, word RAM,
// and an MMIO window holding GPIO, a free-running cycle counter and a sticky error flag.
module dmem_mmio_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32'd16,
    parameter int unsigned       ADDR_W      = 32'd16,
    parameter int unsigned       DEPTH       = 32'd64,
    parameter int unsigned       WAIT_STATES = 32'd1,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = 16'hFF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] gpio_out,
    output logic              err
);

    localparam int unsigned BSH   = $clog2(DATA_W / 32'd8);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [2:0]  WAIT_LAST =
        (WAIT_STATES == 32'd0) ? 3'd0 : 3'(WAIT_STATES - 32'd1);

    state_e            state_r, state_nx_s;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [2:0]        wait_cnt_r;
    logic              ready_r, busy_r, err_r, ram_sel_r;
    logic [DATA_W-1:0] gpio_r, cyc_r, mmio_rdata_r;

    logic              acc_we_s;
    logic [ADDR_W-1:0] acc_addr_s, acc_idx_s, mmio_off_s;
    logic [DATA_W-1:0] acc_wdata_s, mmio_val_s, ram_rdata_s;
    logic [2:0]        slot_s;
    region_e           region_s;
    logic              commit_s, ram_we_s, wr_gpio_s, wr_cycle_s, wr_status_s;

    // The access being worked on: live inputs while idle (zero-wait path), captured copy later
    always_comb begin
        acc_we_s    = we_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        if (state_r == IDLE) begin
            acc_we_s    = we;
            acc_addr_s  = addr;
            acc_wdata_s = wdata;
        end else begin
            acc_we_s    = we_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
    end

    // Region decode; the MMIO window shadows any RAM word it overlaps
    always_comb begin
        acc_idx_s  = acc_addr_s >> BSH;
        mmio_off_s = acc_addr_s - MMIO_BASE;
        slot_s     = 3'(mmio_off_s >> BSH);
        region_s   = ERR;
        if ((acc_addr_s >= MMIO_BASE) && (mmio_off_s < ADDR_W'(MMIO_WINDOW_BYTES))) begin
            region_s = MMIO;
        end else if (acc_idx_s < ADDR_W'(DEPTH)) begin
            region_s = RAM;
        end else begin
            region_s = ERR;
        end
    end

    // Handshake next-state; commit happens on the edge that enters RESP
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_nx_s = (WAIT_STATES == 32'd0) ? RESP : WAIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
        commit_s    = (state_nx_s == RESP);
        ram_we_s    = !reset && commit_s && (region_s == RAM) && acc_we_s;
        wr_gpio_s   = commit_s && (region_s == MMIO) && acc_we_s && (slot_s == MMIO_GPIO);
        wr_cycle_s  = commit_s && (region_s == MMIO) && acc_we_s && (slot_s == MMIO_CYCLE);
        wr_status_s = commit_s && (region_s == MMIO) && acc_we_s && (slot_s == MMIO_STATUS);
    end

    // MMIO read mux; counter value is the one present at the commit edge
    always_comb begin
        mmio_val_s = {DATA_W{1'b0}};
        case (slot_s)
            MMIO_GPIO:   mmio_val_s = gpio_r;
            MMIO_CYCLE:  mmio_val_s = cyc_r;
            MMIO_STATUS: mmio_val_s = {{(DATA_W - 1){1'b0}}, err_r};
            MMIO_RSVD:   mmio_val_s = {DATA_W{1'b0}};
            default:     mmio_val_s = {DATA_W{1'b0}};
        endcase
    end

    // FSM state, request capture, wait counter and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            we_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            wait_cnt_r <= 3'd0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == RESP);
            busy_r  <= (state_nx_s != IDLE);
            if ((state_r == IDLE) && req) begin
                we_r    <= we;
                addr_r  <= addr;
                wdata_r <= wdata;
            end
            if (state_r == WAIT) begin
                wait_cnt_r <= wait_cnt_r + 3'd1;
            end else begin
                wait_cnt_r <= 3'd0;
            end
        end
    end

    // MMIO registers, sticky error and read-data holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_r       <= {DATA_W{1'b0}};
            cyc_r        <= {DATA_W{1'b0}};
            err_r        <= 1'b0;
            mmio_rdata_r <= {DATA_W{1'b0}};
            ram_sel_r    <= 1'b0;
        end else begin
            if (wr_gpio_s) begin
                gpio_r <= acc_wdata_s;
            end
            cyc_r <= wr_cycle_s ? {DATA_W{1'b0}} : (cyc_r + DATA_W'(1'b1));
            if (commit_s && (region_s == ERR)) begin
                err_r <= 1'b1;
            end else if (wr_status_s && acc_wdata_s[0]) begin
                err_r <= 1'b0;
            end
            // Both read paths drop back to zero one edge after the ready cycle
            mmio_rdata_r <= (commit_s && (region_s == MMIO) && !acc_we_s) ? mmio_val_s
                                                                          : {DATA_W{1'b0}};
            ram_sel_r    <= commit_s && (region_s == RAM) && !acc_we_s;
        end
    end

    ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .idx   (acc_idx_s[IDX_W-1:0]),
        .wdata (acc_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign rdata    = ram_sel_r ? ram_rdata_s : mmio_rdata_r;
    assign ready    = ready_r;
    assign busy     = busy_r;
    assign gpio_out = gpio_r;
    assign err      = err_r;

endmodule
